// File: rtl/alu_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_param_if : start/operand/result bus of the sequential ALU      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface alu_param_if #(
    parameter int WIDTH = 8
);
    logic             BEGIN;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] inbus;
    logic [WIDTH-1:0] outbus;
    logic             END;
    logic             FLAG;

    modport master (
        output BEGIN, op_code, inbus,
        input  outbus, END, FLAG
    );

    modport slave (
        input  BEGIN, op_code, inbus,
        output outbus, END, FLAG
    );
endinterface
`default_nettype wire

// File: rtl/alu_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_param : multi-cycle ALU (add/sub, Booth mul, restoring div)    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_param #(
    parameter int WIDTH = 8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    alu_param_if.slave bus
);
    localparam int         c_cw     = $clog2(WIDTH + 1);
    localparam int         c_aw     = 2 * WIDTH + 2;
    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_mul = 2'b10;
    localparam logic [1:0] c_op_div = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        OUT_HI = 3'd4,
        OUT_LO = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [c_aw-1:0]  r_acc;
    logic [c_cw-1:0]  r_cnt;

    logic             w_last;
    logic             w_bzero;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH:0]   w_aext;
    logic [WIDTH:0]   w_bh;
    logic [WIDTH:0]   w_bh_new;
    logic [c_aw-1:0]  w_booth;
    logic [WIDTH:0]   w_rsh;
    logic             w_ge;
    logic [WIDTH:0]   w_rnew;
    logic [c_aw-1:0]  w_div;
    logic [WIDTH-1:0] w_out;
    logic             w_end;
    logic             w_flag;

    assign w_last  = (r_cnt == c_cw'(WIDTH - 1));
    assign w_bzero = (r_b == '0);

    assign w_sum     = r_a + r_b;
    assign w_dif     = r_a - r_b;
    assign w_add_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    assign w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);

    // Booth: acc = {hi (WIDTH+1, one guard bit), multiplier, q-1}; the guard bit
    // keeps hi +/- A from overflowing when A is the most negative value.
    assign w_aext = {r_a[WIDTH-1], r_a};
    assign w_bh   = r_acc[c_aw-1:WIDTH+1];

    always_comb begin
        w_bh_new = w_bh;
        case (r_acc[1:0])
            2'b01:   w_bh_new = w_bh + w_aext;
            2'b10:   w_bh_new = w_bh - w_aext;
            default: w_bh_new = w_bh;
        endcase
    end

    assign w_booth = {w_bh_new[WIDTH], w_bh_new, r_acc[WIDTH:1]};

    // Restoring division: acc = {0, remainder (WIDTH+1), dividend/quotient}.
    assign w_rsh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge   = (w_rsh >= {1'b0, r_b});
    assign w_rnew = w_ge ? (w_rsh - {1'b0, r_b}) : w_rsh;
    assign w_div  = {1'b0, w_rnew, r_acc[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_op    <= c_op_add;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.BEGIN) begin
                        r_op <= bus.op_code;
                    end
                end
                LOAD_A: r_a <= bus.inbus;
                LOAD_B: begin
                    r_b   <= bus.inbus;
                    r_cnt <= '0;
                    if (r_op == c_op_mul) begin
                        r_acc <= {{(WIDTH+1){1'b0}}, bus.inbus, 1'b0};
                    end else begin
                        r_acc <= {{(WIDTH+2){1'b0}}, r_a};
                    end
                end
                EXEC: begin
                    if (r_cnt != c_cw'(WIDTH)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (r_op == c_op_mul) begin
                        r_acc <= w_booth;
                    end else if ((r_op == c_op_div) && !w_bzero) begin
                        r_acc <= w_div;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        w_out  = '0;
        w_end  = 1'b0;
        w_flag = 1'b0;
        case (r_state)
            IDLE:   if (bus.BEGIN) w_next = LOAD_A;
            LOAD_A: w_next = LOAD_B;
            LOAD_B: w_next = EXEC;
            EXEC: begin
                if (!r_op[1]) begin
                    w_next = OUT_LO;
                end else if (w_last || ((r_op == c_op_div) && w_bzero)) begin
                    w_next = OUT_HI;
                end
            end
            OUT_HI: begin
                w_next = OUT_LO;
                if (r_op == c_op_mul) begin
                    w_out = r_acc[2*WIDTH:WIDTH+1];
                end else if (w_bzero) begin
                    w_out = r_a;
                end else begin
                    w_out = r_acc[2*WIDTH-1:WIDTH];
                end
            end
            OUT_LO: begin
                w_next = IDLE;
                w_end  = 1'b1;
                case (r_op)
                    c_op_add: begin
                        w_out  = w_sum;
                        w_flag = w_add_ovf;
                    end
                    c_op_sub: begin
                        w_out  = w_dif;
                        w_flag = w_sub_ovf;
                    end
                    c_op_mul: w_out = r_acc[WIDTH:1];
                    default: begin
                        w_out  = w_bzero ? {WIDTH{1'b1}} : r_acc[WIDTH-1:0];
                        w_flag = w_bzero;
                    end
                endcase
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.outbus = w_out;
    assign bus.END    = w_end;
    assign bus.FLAG   = w_flag;
endmodule
`default_nettype wire

// File: tb/tb_alu_param.sv
`default_nettype none
// Directed vector bench for alu_param: WIDTH=8 table plus WIDTH=16 and reset sequences.
module tb_alu_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_param_if #(.WIDTH(8))  bus8 ();
    alu_param_if #(.WIDTH(16)) bus16 ();

    alu_param #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
    alu_param #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       fl;
        int         lat;
    } vec_t;

    vec_t vecs [0:12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drv(input bit w16, input logic bg, input logic [1:0] op, input logic [31:0] d);
        if (w16) begin
            bus16.BEGIN = bg; bus16.op_code = op; bus16.inbus = d[15:0];
        end else begin
            bus8.BEGIN = bg; bus8.op_code = op; bus8.inbus = d[7:0];
        end
    endtask

    function automatic logic [31:0] get_out(input bit w16);
        return w16 ? 32'(bus16.outbus) : 32'(bus8.outbus);
    endfunction

    function automatic logic [31:0] get_end(input bit w16);
        return w16 ? 32'(bus16.END) : 32'(bus8.END);
    endfunction

    function automatic logic [31:0] get_flag(input bit w16);
        return w16 ? 32'(bus16.FLAG) : 32'(bus8.FLAG);
    endfunction

    // Caller must be just after a falling edge; this cycle becomes c0.
    task automatic run_op(input bit w16, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input logic fl, input int lat, input int id);
        drv(w16, 1'b1, op, 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_c1_out", id), get_out(w16), 32'h0);
        drv(w16, 1'b1, op ^ 2'b11, a);
        @(negedge clk);
        chk($sformatf("v%0d_c2_out", id), get_out(w16), 32'h0);
        drv(w16, 1'b1, op ^ 2'b11, b);
        for (int k = 3; k <= lat; k++) begin
            @(negedge clk);
            if (k == lat) begin
                chk($sformatf("v%0d_c%0d_lo", id, k), get_out(w16), lo);
                chk($sformatf("v%0d_c%0d_end", id, k), get_end(w16), 32'h1);
                chk($sformatf("v%0d_c%0d_flag", id, k), get_flag(w16), 32'(fl));
            end else if ((k == lat - 1) && op[1]) begin
                chk($sformatf("v%0d_c%0d_hi", id, k), get_out(w16), hi);
                chk($sformatf("v%0d_c%0d_end", id, k), get_end(w16), 32'h0);
            end else begin
                chk($sformatf("v%0d_c%0d_out", id, k), get_out(w16) | get_end(w16), 32'h0);
            end
            drv(w16, (k < lat), op ^ 2'b11, ~b);
        end
        @(negedge clk);
        chk($sformatf("v%0d_idle", id), get_out(w16) | get_end(w16) | get_flag(w16), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1;
        int e2;
        int n_end;

        vecs[0]  = '{2'b00, 8'd56,  8'd89,  8'h00, 8'h91, 1'b1, 4};
        vecs[1]  = '{2'b01, 8'd56,  8'd89,  8'h00, 8'hDF, 1'b0, 4};
        vecs[2]  = '{2'b00, 8'h80,  8'h80,  8'h00, 8'h00, 1'b1, 4};
        vecs[3]  = '{2'b01, 8'h80,  8'h01,  8'h00, 8'h7F, 1'b1, 4};
        vecs[4]  = '{2'b00, 8'hFF,  8'h01,  8'h00, 8'h00, 1'b0, 4};
        vecs[5]  = '{2'b10, 8'd7,   8'd3,   8'h00, 8'h15, 1'b0, 12};
        vecs[6]  = '{2'b10, 8'hF9,  8'd3,   8'hFF, 8'hEB, 1'b0, 12};
        vecs[7]  = '{2'b10, 8'h80,  8'h80,  8'h40, 8'h00, 1'b0, 12};
        vecs[8]  = '{2'b10, 8'h7F,  8'h80,  8'hC0, 8'h80, 1'b0, 12};
        vecs[9]  = '{2'b11, 8'd100, 8'd7,   8'h02, 8'h0E, 1'b0, 12};
        vecs[10] = '{2'b11, 8'd45,  8'd0,   8'h2D, 8'hFF, 1'b1, 5};
        vecs[11] = '{2'b11, 8'hFF,  8'h01,  8'h00, 8'hFF, 1'b0, 12};
        vecs[12] = '{2'b11, 8'd5,   8'd200, 8'h05, 8'h00, 1'b0, 12};

        drv(1'b0, 1'b0, 2'b00, 32'h0);
        drv(1'b1, 1'b0, 2'b00, 32'h0);
        #12;
        chk("reset_out", get_out(1'b0), 32'h0);
        chk("reset_end", get_end(1'b0), 32'h0);
        chk("reset_flag", get_flag(1'b0), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i <= 12; i++) begin
            run_op(1'b0, vecs[i].op, 32'(vecs[i].a), 32'(vecs[i].b), 32'(vecs[i].hi),
                   32'(vecs[i].lo), vecs[i].fl, vecs[i].lat, i);
        end

        // Reset during MUL EXEC (c6): no END, then ADD on first edge after release.
        drv(1'b0, 1'b1, 2'b10, 32'h0);
        @(negedge clk); drv(1'b0, 1'b0, 2'b00, 32'd7);
        @(negedge clk); drv(1'b0, 1'b0, 2'b00, 32'd3);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("rst_c6_out", get_out(1'b0) | get_end(1'b0) | get_flag(1'b0), 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_c6_hold", get_end(1'b0), 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        run_op(1'b0, 2'b00, 32'd1, 32'd2, 32'h0, 32'h03, 1'b0, 4, 20);

        // Reset during OUT_HI (c11) must clear a nonzero outbus at once.
        drv(1'b0, 1'b1, 2'b10, 32'h0);
        @(negedge clk); drv(1'b0, 1'b0, 2'b00, 32'hF9);
        @(negedge clk); drv(1'b0, 1'b0, 2'b00, 32'd3);
        repeat (9) @(negedge clk);
        chk("rst_c11_pre", get_out(1'b0), 32'hFF);
        #2 reset = 1'b0;
        #1 chk("rst_c11_out", get_out(1'b0) | get_end(1'b0), 32'h0);
        @(negedge clk);
        chk("rst_c11_noend", get_end(1'b0), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_c11_idle", get_out(1'b0) | get_end(1'b0), 32'h0);

        run_op(1'b1, 2'b10, 32'd300, 32'hFFFE, 32'hFFFF, 32'hFDA8, 1'b0, 20, 30);

        // Back-to-back ADDs with BEGIN held high on WIDTH=16.
        e1 = -1; e2 = -1; n_end = 0;
        drv(1'b1, 1'b1, 2'b00, 32'h0102);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 6) bus16.BEGIN = 1'b0;
            if (bus16.END) begin
                n_end++;
                if (e1 < 0) e1 = k;
                else if (e2 < 0) e2 = k;
                chk("b2b_out", get_out(1'b1), 32'h0204);
            end
        end
        chk("b2b_count", 32'(n_end), 32'd2);
        chk("b2b_first", 32'(e1), 32'd4);
        chk("b2b_gap", 32'(e2 - e1), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_param.md
ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 Parameter WIDTH, default 8, operand/result word width in bits; legal range 4..32.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset asserted when low.
REQ-004 BEGIN  input  1  start request, sampled only in IDLE.
REQ-005 op_code  input  2  00 ADD, 01 SUB, 10 MUL (signed), 11 DIV (unsigned); sampled with BEGIN.
REQ-006 inbus  input  WIDTH  operand input bus: operand A in first load cycle, operand B in second.
REQ-007 outbus  output  WIDTH  result word; 0 when no result word is presented.
REQ-008 END  output  1  one-cycle pulse marking the final result word.
REQ-009 FLAG  output  1  status bit; valid only in the END cycle, 0 otherwise.

Function
REQ-010 FSM states SHALL be IDLE, LOAD_A, LOAD_B, EXEC, OUT_HI, OUT_LO.
REQ-011 Cycle numbering: c0 is the IDLE cycle in which BEGIN=1 is sampled; op_code is captured at the end of c0.
REQ-012 Transitions: IDLE->LOAD_A on BEGIN=1, else stay; LOAD_A->LOAD_B; LOAD_B->EXEC; EXEC->OUT_LO (ADD/SUB) or OUT_HI (MUL/DIV) when done; OUT_HI->OUT_LO; OUT_LO->IDLE.
REQ-013 LOAD_A (c1) SHALL capture inbus into A; LOAD_B (c2) SHALL capture inbus into B; inbus is ignored in all other states.
REQ-014 BEGIN and op_code outside IDLE SHALL be ignored; BEGIN high in IDLE immediately after OUT_LO SHALL start a new operation (back-to-back allowed).
REQ-015 ADD/SUB: EXEC lasts 1 cycle (c3); result A+B or A-B modulo 2^WIDTH on outbus in c4 with END=1.
REQ-016 ADD/SUB FLAG SHALL equal two's-complement signed overflow of the operation.
REQ-017 MUL: radix-2 Booth, signed operands, one iteration per cycle, exactly WIDTH EXEC cycles (c3..c(2+WIDTH)).
REQ-018 MUL: 2*WIDTH-bit signed product; high word on outbus in OUT_HI (c(3+WIDTH)), low word in OUT_LO (c(4+WIDTH)) with END=1; FLAG=0.
REQ-019 DIV: unsigned restoring division, one quotient bit per cycle, exactly WIDTH EXEC cycles; remainder in OUT_HI, quotient in OUT_LO with END=1; FLAG=0.
REQ-020 DIV with B=0: EXEC lasts 1 cycle (c3); OUT_HI (c4) = A, OUT_LO (c5) = all ones with END=1 and FLAG=1.
REQ-021 Iteration count SHALL be held in an internal counter of ceil(log2(WIDTH+1)) bits; the counter SHALL NOT wrap.
REQ-022 END SHALL be high for exactly one cycle per operation, only in OUT_LO.
REQ-023 outbus SHALL be 0 in IDLE, LOAD_A, LOAD_B and EXEC.

Reset
REQ-024 reset low SHALL immediately force IDLE, outbus=0, END=0, FLAG=0 and clear A, B, the accumulator and the counter, independent of clk.
REQ-025 reset asserted mid-operation SHALL abort it with no END pulse; the first rising clk edge after reset deasserts SHALL accept a new BEGIN.

Verification (WIDTH=8 unless stated)
REQ-026 ADD: A=56, B=89 -> outbus 0x91, END and FLAG=1 in c4 (signed overflow).
REQ-027 SUB: A=56, B=89 -> outbus 0xDF, END=1, FLAG=0 in c4; outbus 0 in c1..c3.
REQ-028 MUL: A=7, B=3 -> OUT_HI 0x00 (c11), OUT_LO 0x15 with END (c12); A=-7 (0xF9), B=3 -> 0xFF then 0xEB.
REQ-029 DIV: A=100, B=7 -> 0x02 (c11), 0x0E with END, FLAG=0 (c12); A=45, B=0 -> 0x2D (c4), 0xFF with END and FLAG=1 (c5).
REQ-030 reset pulled low at c6 of a MUL -> outputs 0 immediately, no END; following ADD 1+2 -> 0x03 with END at c4.
REQ-031 WIDTH=16: MUL A=300, B=-2 -> 0xFFFF (c19), 0xFDA8 with END (c20); back-to-back BEGIN held high runs two ADDs with END pulses exactly 5 cycles apart.
